// File: rtl/uart_pkg.sv
// Shared definitions for the serial link: baud default, frame shape and the
// transmitter state encoding (the receiver draws on the same package).
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;

    typedef enum logic [2:0] {
        TX_IDLE    = 3'd0,
        TX_START   = 3'd1,
        TX_DATA    = 3'd2,
        TX_STOP    = 3'd3,
        TX_CLEANUP = 3'd4
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a registered read port, so the
// storage maps onto block RAM. Popped data appears on o_Data the cycle after the pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     i_Clock,
    input  logic                     reset,
    input  logic                     i_Push,
    input  logic [WIDTH-1:0]         i_Data,
    input  logic                     i_Pop,
    output logic [WIDTH-1:0]         o_Data,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_Mem [DEPTH];
    logic [WIDTH-1:0] r_Data;
    logic [AW-1:0]    r_Wr_Ptr;
    logic [AW-1:0]    r_Rd_Ptr;
    logic [AW:0]      r_Count;
    logic             w_Do_Push;
    logic             w_Do_Pop;

    // Requests are qualified here too, so a careless client cannot corrupt the pointers.
    assign w_Do_Push = i_Push && !o_Full;
    assign w_Do_Pop  = i_Pop && !o_Empty;

    always_ff @(posedge i_Clock) begin
        if (w_Do_Push) begin
            r_Mem[r_Wr_Ptr] <= i_Data;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (w_Do_Pop) begin
            r_Data <= r_Mem[r_Rd_Ptr];
        end
    end

    always_ff @(posedge i_Clock) begin
        if (reset) begin
            r_Wr_Ptr <= '0;
            r_Rd_Ptr <= '0;
            r_Count  <= '0;
        end else begin
            if (w_Do_Push) begin
                r_Wr_Ptr <= r_Wr_Ptr + 1'b1;
            end
            if (w_Do_Pop) begin
                r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
            end
            case ({w_Do_Push, w_Do_Pop})
                2'b10:   r_Count <= r_Count + 1'b1;
                2'b01:   r_Count <= r_Count - 1'b1;
                default: r_Count <= r_Count;
            endcase
        end
    end

    assign o_Data  = r_Data;
    assign o_Full  = (r_Count == (AW + 1)'(DEPTH));
    assign o_Empty = (r_Count == '0);
    assign o_Level = r_Count;

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 transmitter: bytes queue in a FIFO and are shifted out LSB
// first; the transmit gate only controls whether a new frame may begin.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_Clock,
    input  logic                          reset,
    input  logic                          i_Tx_DV,
    input  logic [7:0]                    i_Tx_Byte,
    input  logic                          transmit,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic                          o_Empty,
    output logic                          o_Full,
    output logic [$clog2(FIFO_DEPTH):0]   o_Level,
    output logic                          o_Overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    tx_state_t        r_State;
    tx_state_t        w_State_Next;
    logic [CW-1:0]    r_Clk_Count;
    logic [CW-1:0]    w_Clk_Count_Next;
    logic [BW-1:0]    r_Bit_Index;
    logic [BW-1:0]    w_Bit_Index_Next;
    logic [7:0]       r_Shift;
    logic [7:0]       w_Shift_Next;
    logic             r_Tx_Serial;
    logic             r_Tx_Active;
    logic             r_Tx_Done;
    logic             r_Overflow;
    logic             w_Line;
    logic             w_Active;
    logic             w_Done;
    logic             w_Pop;
    logic             w_Push;
    logic             w_Clk_Last;
    logic [7:0]       w_Fifo_Data;
    logic             w_Full;
    logic             w_Empty;

    // Full is the registered flag, so a write in the same cycle as a pop from a full FIFO is still dropped.
    assign w_Push     = i_Tx_DV && !w_Full;
    assign w_Clk_Last = (r_Clk_Count == LAST_CLK);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock (i_Clock),
        .reset   (reset),
        .i_Push  (w_Push),
        .i_Data  (i_Tx_Byte),
        .i_Pop   (w_Pop),
        .o_Data  (w_Fifo_Data),
        .o_Full  (w_Full),
        .o_Empty (w_Empty),
        .o_Level (o_Level)
    );

    always_comb begin
        w_State_Next     = r_State;
        w_Clk_Count_Next = r_Clk_Count;
        w_Bit_Index_Next = r_Bit_Index;
        w_Shift_Next     = r_Shift;
        w_Line           = 1'b1;
        w_Active         = 1'b0;
        w_Done           = 1'b0;
        w_Pop            = 1'b0;
        case (r_State)
            TX_IDLE: begin
                w_Clk_Count_Next = '0;
                if (transmit && !w_Empty) begin
                    w_Pop            = 1'b1;
                    w_Bit_Index_Next = '0;
                    w_State_Next     = TX_START;
                end
            end
            TX_START: begin
                w_Line   = 1'b0;
                w_Active = 1'b1;
                // The FIFO read is registered: the popped byte is valid on the first start-bit cycle.
                if (r_Clk_Count == '0) begin
                    w_Shift_Next = w_Fifo_Data;
                end
                if (w_Clk_Last) begin
                    w_Clk_Count_Next = '0;
                    w_State_Next     = TX_DATA;
                end else begin
                    w_Clk_Count_Next = r_Clk_Count + 1'b1;
                end
            end
            TX_DATA: begin
                w_Line   = r_Shift[0];
                w_Active = 1'b1;
                if (w_Clk_Last) begin
                    w_Clk_Count_Next = '0;
                    w_Shift_Next     = {1'b0, r_Shift[7:1]};
                    if (r_Bit_Index == LAST_DATA) begin
                        w_Bit_Index_Next = '0;
                        w_State_Next     = TX_STOP;
                    end else begin
                        w_Bit_Index_Next = r_Bit_Index + 1'b1;
                    end
                end else begin
                    w_Clk_Count_Next = r_Clk_Count + 1'b1;
                end
            end
            TX_STOP: begin
                w_Active = 1'b1;
                if (w_Clk_Last) begin
                    w_Clk_Count_Next = '0;
                    if (r_Bit_Index == LAST_STOP) begin
                        w_Bit_Index_Next = '0;
                        w_State_Next     = TX_CLEANUP;
                    end else begin
                        w_Bit_Index_Next = r_Bit_Index + 1'b1;
                    end
                end else begin
                    w_Clk_Count_Next = r_Clk_Count + 1'b1;
                end
            end
            TX_CLEANUP: begin
                w_Done       = 1'b1;
                w_State_Next = TX_IDLE;
            end
            default: begin
                w_State_Next = TX_IDLE;
            end
        endcase
    end

    // Line, active and done are registered copies of the state decode, so they move together.
    always_ff @(posedge i_Clock) begin
        if (reset) begin
            r_State     <= TX_IDLE;
            r_Clk_Count <= '0;
            r_Bit_Index <= '0;
            r_Shift     <= '0;
            r_Tx_Serial <= 1'b1;
            r_Tx_Active <= 1'b0;
            r_Tx_Done   <= 1'b0;
            r_Overflow  <= 1'b0;
        end else begin
            r_State     <= w_State_Next;
            r_Clk_Count <= w_Clk_Count_Next;
            r_Bit_Index <= w_Bit_Index_Next;
            r_Shift     <= w_Shift_Next;
            r_Tx_Serial <= w_Line;
            r_Tx_Active <= w_Active;
            r_Tx_Done   <= w_Done;
            r_Overflow  <= i_Tx_DV && w_Full;
        end
    end

    assign o_Tx_Serial = r_Tx_Serial;
    assign o_Tx_Active = r_Tx_Active;
    assign o_Tx_Done   = r_Tx_Done;
    assign o_Overflow  = r_Overflow;
    assign o_Empty     = w_Empty;
    assign o_Full      = w_Full;

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1 UART transmitter: the host-bound side of the accelerator's serial link, complementing the existing UART receiver. Core logic pushes result bytes into a small FIFO; the block serialises them LSB-first at the same CLKS_PER_BIT baud setting the receiver uses. A `transmit` gate lets the top-level controller hold output until the host is ready.

## Interface
- CLKS_PER_BIT, 434: clock cycles per serial bit (100 MHz / 230400 baud); must be ≥ 2.
- FIFO_DEPTH, 16: byte FIFO entries; power of two, ≥ 2.
- i_Clock  in  1  system clock.
- reset  in  1  synchronous, active-high; clock i_Clock.
- i_Tx_DV  in  1  write strobe; pushes i_Tx_Byte into the FIFO when not full.
- i_Tx_Byte  in  8  byte to send.
- transmit  in  1  enables starting a new frame; never aborts a frame in progress.
- o_Tx_Serial  out  1  serial line; idle high.
- o_Tx_Active  out  1  high from the first start-bit cycle through the last stop-bit cycle.
- o_Tx_Done  out  1  one-cycle pulse on the cycle after the last stop-bit cycle.
- o_Empty  out  1  FIFO empty.
- o_Full  out  1  FIFO full.
- o_Level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_Overflow  out  1  one-cycle pulse when a write is dropped.

## Operation
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Empty=1, o_Full=0, o_Level=0, o_Overflow=0; FIFO flushed; state IDLE.
- FIFO write: i_Tx_DV && !o_Full stores the byte. If i_Tx_DV && o_Full, the byte is dropped and o_Overflow pulses on the next cycle. Full is evaluated on pre-edge state, so a write while full is dropped even when a pop occurs in the same cycle.
- Simultaneous push and pop with 0 < level < FIFO_DEPTH: level unchanged, order preserved.
- States:
  - IDLE: line high. If transmit && !o_Empty, pop the head into the shift register, clear the bit counter, go to START.
  - START: line 0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: line = shift[0] for CLKS_PER_BIT cycles per bit, bit index 0..7; after bit 7, go to STOP.
  - STOP: line 1 for CLKS_PER_BIT cycles; on exit o_Tx_Done=1, go to CLEANUP.
  - CLEANUP: line 1, one cycle, then IDLE.
- Unused encodings return to IDLE with the line high.
- transmit deasserted mid-frame: the current frame completes normally; no new frame starts until transmit rises.
- Reset mid-frame: line high on the next cycle; no o_Tx_Done; FIFO contents lost.
- o_Tx_Serial is driven from a flop; no combinational path from any input.

## Timing
- Clock-count width: $clog2(CLKS_PER_BIT). Count 0..CLKS_PER_BIT-1 per bit, then wrap to 0.
- Latency, write to start bit (empty FIFO, idle, transmit=1): write at edge N → byte visible at N+1 → popped in IDLE at N+1 → o_Tx_Serial falls at edge N+2.
- Frame length: exactly 10×CLKS_PER_BIT cycles with o_Tx_Active=1.
- Back-to-back frames: 2 extra high cycles (CLEANUP + IDLE) after each stop bit before the next start bit.
- o_Level and flags update one cycle after the write or pop edge.

## Structure
- Shared package uart_pkg: default CLKS_PER_BIT, TX state encoding (3-bit: IDLE, START, DATA, STOP, CLEANUP), frame constants (DATA_BITS=8, STOP_BITS=1). The receiver moves to the same package.
- Sub-module sync_fifo: parameterised WIDTH=8, DEPTH; push, pop, full, empty, level; registered output; reusable by other blocks. uart_tx holds only the FSM, counters, shift register and overflow logic.

## Test plan
Run with CLKS_PER_BIT=4, FIFO_DEPTH=4.
- Single byte 0xA5, transmit=1 → line falls 2 cycles after the write; bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; o_Tx_Active high for 40 cycles; o_Tx_Done pulses once; o_Empty returns to 1.
- transmit=0, write 0x11,0x22,0x33,0x44,0x55 → o_Full=1 and o_Level=4 after the fourth write; fifth write dropped with one o_Overflow pulse; then transmit=1 → four frames in order with 2-cycle gaps; 0x55 never sent.
- Write 0x3C, then drop transmit to 0 during data bit 3 with two more bytes queued → 0x3C completes intact; line stays high and o_Level stays 2 until transmit returns to 1.
- Reset asserted during data bit 5 of 0xFF, with 2 bytes queued → next cycle line=1, o_Tx_Active=0, o_Level=0, o_Empty=1; no o_Tx_Done pulse.
- Level=4 (full) during an active frame: write at the same edge IDLE pops → write dropped with an o_Overflow pulse. Then at level 2, push and pop in the same edge → level stays 2 and byte order is preserved.
